// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, lookups and byte/word helpers for AES key expansion
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128 = 2'd0,
        KEY_192 = 2'd1,
        KEY_256 = 2'd2,
        KEY_ILL = 2'd3
    } key_len_e;

    localparam int NK_128 = 4;
    localparam int NK_192 = 6;
    localparam int NK_256 = 8;
    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;
    localparam int MAX_NR = 14;
    localparam int IDX_W  = $clog2(MAX_NR + 1);

    typedef logic [3:0][31:0] rk_t;

    function automatic int nk_of(input key_len_e k);
        case (k)
            KEY_128: return NK_128;
            KEY_192: return NK_192;
            KEY_256: return NK_256;
            default: return 0;
        endcase
    endfunction

    function automatic int nr_of(input key_len_e k);
        case (k)
            KEY_128: return NR_128;
            KEY_192: return NR_192;
            KEY_256: return NR_256;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_rk_fifo.sv
// rtl/aes_rk_fifo.sv - round-key output FIFO carrying {round key, index, last flag}
module aes_rk_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  rk_t              push_data,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             push_last,
    input  logic             pop,
    output logic             valid,
    output logic             full,
    output rk_t              data,
    output logic [IDX_W-1:0] idx,
    output logic             last
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        rk_t              data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        wr_entry;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign valid    = (count != '0);
    assign full     = (count == (AW + 1)'(DEPTH));
    assign do_pop   = pop && valid;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_push  = push && (!full || do_pop);
    assign wr_entry = '{data: push_data, idx: push_idx, last: push_last};

    assign data = mem[rd_ptr].data;
    assign idx  = mem[rd_ptr].idx;
    assign last = mem[rd_ptr].last;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - AES forward S-box (GF(2^8) inverse + affine), built only with AES_KEY_INT_SBOX_EN
`ifdef AES_KEY_INT_SBOX_EN
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] xv;
        logic [7:0] zv;
        p  = 8'h00;
        xv = x;
        zv = z;
        for (int k = 0; k < 8; k++) begin
            if (zv[0]) p = p ^ xv;
            xv = xtime(xv);
            zv = {1'b0, zv[7:1]};
        end
        return p;
    endfunction

    logic [7:0] inv;

    // Inverse as a^254 (square-and-multiply over 0b11111110); maps 0 to 0.
    always_comb begin
        inv = 8'h01;
        for (int k = 7; k >= 0; k--) begin
            inv = gf_mul(inv, inv);
            if (k != 0) inv = gf_mul(inv, a);
        end
    end

    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule
`endif

// File: rtl/aes_key_expand_mk.sv
// rtl/aes_key_expand_mk.sv - word-serial AES-128/192/256 key expansion; AES_KEY_INT_SBOX_EN selects internal S-boxes
module aes_key_expand_mk
    import aes_pkg::*;
#(
    parameter int MAX_NK    = 8,
    parameter int OUT_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [MAX_NK*32-1:0]  key_i,
    output logic                  busy,
    output logic                  err,
    output logic [31:0]           sub_o,
    input  logic [31:0]           sub_i,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic [127:0]          rk_data,
    output logic [3:0]            rk_idx,
    output logic                  rk_last
);
    localparam int IW = $clog2(MAX_NK);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DRAIN  = 2'd2
    } state_e;

    state_e      state;
    state_e      state_nxt;

    // Sliding window of the last Nk words: win[0] = w[i-Nk], win[nk_m1] = w[i-1].
    logic [31:0] win [MAX_NK];
    logic [IW-1:0] nk_m1;
    logic [IW-1:0] mod_cnt;
    logic        is_nk8;
    logic        key_phase;
    logic [5:0]  i_cnt;
    logic [5:0]  last_i;
    logic [7:0]  rcon;
    rk_t         pack;
    rk_t         pack_nxt;
    logic [1:0]  pack_cnt;

    key_len_e    kl;
    logic        legal;
    logic        accept;
    logic        pop;
    logic        stall;
    logic        advance;
    logic        push;

    logic [31:0] prev_w;
    logic        need_rot;
    logic        need_sub8;
    logic [31:0] sub_w;
    logic [31:0] sub_val;
    logic [31:0] t_w;
    logic [31:0] w_new;

    rk_t         fifo_data;
    logic        fifo_full;
    logic        fifo_last;

    assign kl     = key_len_e'(key_len);
    assign legal  = (kl != KEY_ILL) && (nk_of(kl) <= MAX_NK);
    assign accept = (state == S_IDLE) && start && legal;
    assign busy   = (state != S_IDLE);

    assign pop     = rk_valid && rk_ready;
    assign stall   = (pack_cnt == 2'd3) && fifo_full && !pop;
    assign advance = (state == S_EXPAND) && !stall;
    assign push    = advance && (pack_cnt == 2'd3);

    always_comb begin
        prev_w    = win[nk_m1];
        need_rot  = (state == S_EXPAND) && !key_phase && (mod_cnt == '0);
        need_sub8 = (state == S_EXPAND) && !key_phase && is_nk8 && (mod_cnt == IW'(4));
        sub_w     = '0;
        if (need_rot) begin
            sub_w = rot_word(prev_w);
        end else if (need_sub8) begin
            sub_w = prev_w;
        end
    end

`ifdef AES_KEY_INT_SBOX_EN
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (sub_w[g*8 +: 8]),
            .y (sub_val[g*8 +: 8])
        );
    end
    assign sub_o = '0;
`else
    assign sub_val = sub_i;
    assign sub_o   = sub_w;
`endif

    always_comb begin
        t_w = prev_w;
        if (need_rot) begin
            t_w = sub_val ^ {rcon, 24'h0};
        end else if (need_sub8) begin
            t_w = sub_val;
        end
        w_new    = key_phase ? win[0] : (win[0] ^ t_w);
        pack_nxt = pack;
        pack_nxt[2'd3 - pack_cnt] = w_new;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_EXPAND;
            S_EXPAND: if (advance && (i_cnt == last_i)) state_nxt = S_DRAIN;
            S_DRAIN:  if (pop && fifo_last) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= (state == S_IDLE) && start && !legal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_NK; k++) begin
                win[k] <= '0;
            end
            nk_m1     <= '0;
            mod_cnt   <= '0;
            is_nk8    <= 1'b0;
            key_phase <= 1'b0;
            i_cnt     <= '0;
            last_i    <= '0;
            rcon      <= '0;
            pack      <= '0;
            pack_cnt  <= '0;
        end else if (accept) begin
            for (int k = 0; k < MAX_NK; k++) begin
                win[k] <= key_i[(MAX_NK-1-k)*32 +: 32];
            end
            nk_m1     <= IW'(nk_of(kl) - 1);
            mod_cnt   <= '0;
            is_nk8    <= (nk_of(kl) == 8);
            key_phase <= 1'b1;
            i_cnt     <= '0;
            last_i    <= 6'(4 * (nr_of(kl) + 1) - 1);
            rcon      <= 8'h01;
            pack      <= '0;
            pack_cnt  <= '0;
        end else if (advance) begin
            // Rotating the window during the key phase leaves it holding w[0..Nk-1] in order.
            for (int k = 0; k < MAX_NK - 1; k++) begin
                win[k] <= (k == int'(nk_m1)) ? w_new : win[k+1];
            end
            win[MAX_NK-1] <= w_new;
            if (mod_cnt == nk_m1) begin
                mod_cnt   <= '0;
                key_phase <= 1'b0;
            end else begin
                mod_cnt <= mod_cnt + 1'b1;
            end
            if (need_rot) begin
                rcon <= xtime(rcon);
            end
            i_cnt    <= i_cnt + 1'b1;
            pack     <= pack_nxt;
            pack_cnt <= pack_cnt + 1'b1;
        end
    end

    aes_rk_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (pack_nxt),
        .push_idx  (i_cnt[5:2]),
        .push_last (i_cnt == last_i),
        .pop       (pop),
        .valid     (rk_valid),
        .full      (fifo_full),
        .data      (fifo_data),
        .idx       (rk_idx),
        .last      (fifo_last)
    );

    assign rk_data = fifo_data;
    assign rk_last = fifo_last;

endmodule
